// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
// A fetch entry pairs an instruction word with the byte address it came from.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_BYTES      = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush input.
// The head entry reads as zero whenever the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             din_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Flush wins over push and pop; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PW'(1);
            if (pop_i)  rd_d = rd_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_q] <= din_i;
        end
    end

    assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC sequencer feeding an asynchronous-read instruction memory into a small fetch buffer.
// Redirects flush the buffer; a misaligned redirect target raises a sticky fault that halts fetching.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  count_q, count_d;
    logic [CW-1:0] fifoCount;
    logic         doPush;
    logic         doPop;
    fetch_entry_t headEntry;
    fetch_entry_t newEntry;

    // A redirect discards the head, so it never counts as accepted in that cycle.
    assign doPop    = if_valid & if_ready & ~redirect_valid;
    assign doPush   = ~fault_q & ~redirect_valid & ((fifoCount < CW'(FIFO_DEPTH)) | doPop);
    assign newEntry = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'(INSTR_BYTES - 1);
            fault_d = |redirect_pc[1:0];
        end else if (doPush) begin
            pc_d    = pc_q + 32'(INSTR_BYTES);
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (doPush),
        .pop_i   (doPop),
        .flush_i (redirect_valid),
        .din_i   (newEntry),
        .head_o  (headEntry),
        .count_o (fifoCount)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = (fifoCount != '0);
    assign if_instr    = headEntry.instr;
    assign if_pc       = headEntry.pc;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule
